// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: start, transmission bit, index, argument, CRC7, end bit.
// Define SD_CMD_TX_GAP_EN to hold the line driven high for 8 cycles after each token.
module sd_cmd_tx (
  input  logic        sd_clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        ready_o,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        done_o
);

  // Handshake: a request is taken on a rising edge where start_i=1 and ready_o=1;
  // ready_o drops the following cycle and start_i is ignored until ready_o returns.
  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CRC,
`ifdef SD_CMD_TX_GAP_EN
    S_END,
    S_GAP
`else
    S_END
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [39:0] shift_q, shift_d;
  logic [6:0]  crc_q, crc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        fb;
  logic        cmd_d, oe_d, ready_d, done_d;

  always_ff @(posedge sd_clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      crc_q    <= '0;
      cnt_q    <= '0;
      cmd_o    <= 1'b1;
      cmd_oe_o <= 1'b0;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      cmd_o    <= cmd_d;
      cmd_oe_o <= oe_d;
      ready_o  <= ready_d;
      done_o   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    fb      = shift_q[39] ^ crc_q[6];
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_DATA;
          shift_d = {2'b01, cmd_index_i, cmd_arg_i};
          crc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        // The bit on the line this cycle is absorbed into the CRC at the edge.
        shift_d = {shift_q[38:0], 1'b0};
        crc_d   = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd39) begin
          state_d = S_CRC;
          cnt_d   = '0;
        end
      end
      S_CRC: begin
        crc_d = {crc_q[5:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd6) begin
          state_d = S_END;
          cnt_d   = '0;
        end
      end
      S_END: begin
`ifdef SD_CMD_TX_GAP_EN
        state_d = S_GAP;
        cnt_d   = '0;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef SD_CMD_TX_GAP_EN
      S_GAP: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd7) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    case (state_d)
      S_DATA:  cmd_d = shift_d[39];
      S_CRC:   cmd_d = crc_d[6];
      default: cmd_d = 1'b1;
    endcase
    oe_d    = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    done_d  = ready_d && (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: table of known SD command tokens plus hand sequences
// for back-to-back, ignored requests, reset mid-token and idle hold.
module tb_sd_cmd_tx;

`ifdef SD_CMD_TX_GAP_EN
  localparam int GAP = 8;
`else
  localparam int GAP = 0;
`endif

  logic        sd_clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [5:0]  cmd_index_i;
  logic [31:0] cmd_arg_i;
  logic        ready_o, cmd_o, cmd_oe_o, done_o;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] token;
  } vec_t;

  vec_t        vecs [4];
  logic [47:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          exp_done = 0;

  sd_cmd_tx dut (
    .sd_clk_i    (sd_clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .cmd_index_i (cmd_index_i),
    .cmd_arg_i   (cmd_arg_i),
    .ready_o     (ready_o),
    .cmd_o       (cmd_o),
    .cmd_oe_o    (cmd_oe_o),
    .done_o      (done_o)
  );

  // clock / watchdog
  always #5 sd_clk_i = ~sd_clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sd_clk_i);
    #1;
  endtask

  // scoreboard: reassemble tokens seen on the CMD line and compare with exp_q
  initial begin
    logic [47:0] shreg;
    int          nbits;
    bit          collecting;
    collecting = 0;
    nbits      = 0;
    shreg      = '0;
    forever begin
      @(negedge sd_clk_i);
      if (rst_i) begin
        collecting = 0;
      end else begin
        if (done_o === 1'b1) done_seen++;
        if (collecting) begin
          if (cmd_oe_o !== 1'b1) begin
            check("oe_drop_mid_token", 64'(cmd_oe_o), 64'd1);
            collecting = 0;
          end else begin
            shreg = {shreg[46:0], cmd_o};
            nbits++;
            if (nbits == 48) begin
              collecting = 0;
              if (exp_q.size() == 0) check("unexpected_token", 64'(shreg), 64'd0);
              else check("token", 64'(shreg), 64'(exp_q.pop_front()));
            end
          end
        end else if (cmd_oe_o === 1'b1 && cmd_o === 1'b0) begin
          collecting = 1;
          shreg      = '0;
          nbits      = 1;
        end
      end
    end
  end

  // Send table entry vi. hold keeps start_i high through the token (back-to-back);
  // poke_k >= 0 pulses start_i with a different index during bit poke_k.
  task automatic send_tok(input int vi, input bit hold, input int poke_k);
    int          n;
    int          flag_bad;
    int          bit_bad;
    logic [47:0] tok;
    n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("ready_wait_timeout", 64'(n >= 200), 64'd0);
    tok = vecs[vi].token;
    exp_q.push_back(tok);
    start_i     = 1'b1;
    cmd_index_i = vecs[vi].idx;
    cmd_arg_i   = vecs[vi].arg;
    step();
    cmd_index_i = 6'($urandom_range(0, 63));
    cmd_arg_i   = $urandom;
    flag_bad = 0;
    bit_bad  = 0;
    for (int k = 0; k < 48; k++) begin
      start_i = hold || (k == poke_k);
      if (k == poke_k) cmd_index_i = 6'd33;
      if ({cmd_oe_o, ready_o, done_o} !== 3'b100) flag_bad++;
      if (cmd_o !== tok[47-k]) bit_bad++;
      step();
    end
    check("busy_flags", 64'(flag_bad), 64'd0);
    check("bit_timing", 64'(bit_bad), 64'd0);
`ifdef SD_CMD_TX_GAP_EN
    flag_bad = 0;
    for (int g = 0; g < GAP; g++) begin
      if ({cmd_oe_o, cmd_o, ready_o, done_o} !== 4'b1100) flag_bad++;
      step();
    end
    check("gap_flags", 64'(flag_bad), 64'd0);
`endif
    exp_done++;
    check("done_at_end", 64'({done_o, ready_o, cmd_oe_o, cmd_o}), 64'(4'b1101));
    if (!hold) begin
      start_i = 1'b0;
      step();
      check("done_one_cycle", 64'({done_o, ready_o, cmd_oe_o, cmd_o}), 64'(4'b0101));
    end
  endtask

  task automatic idle_hold(input int cycles);
    int bad;
    bad = 0;
    start_i = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if ({cmd_oe_o, cmd_o, done_o} !== 3'b010) bad++;
      step();
    end
    check("idle_hold", 64'(bad), 64'd0);
  endtask

  initial begin
    vecs[0] = '{6'd0,  32'h0000_0000, 48'h40_0000_0000_95};
    vecs[1] = '{6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87};
    vecs[2] = '{6'd17, 32'h0000_0000, 48'h51_0000_0000_55};
    vecs[3] = '{6'd55, 32'h0000_0000, 48'h77_0000_0000_65};

    // clock / reset block
    rst_i       = 1'b1;
    start_i     = 1'b0;
    cmd_index_i = '0;
    cmd_arg_i   = '0;
    repeat (3) step();
    check("reset_state", 64'({ready_o, cmd_o, cmd_oe_o, done_o}), 64'(4'b1100));
    rst_i = 1'b0;
    step();
    check("after_reset", 64'({ready_o, cmd_o, cmd_oe_o, done_o}), 64'(4'b1100));

    idle_hold(100);

    send_tok(0, 1'b0, -1);   // CMD0
    send_tok(1, 1'b0, -1);   // CMD8
    send_tok(2, 1'b1, -1);   // CMD17, start_i held high
    send_tok(3, 1'b0, -1);   // CMD55 accepted in the done cycle
    send_tok(1, 1'b0, 10);   // CMD8 with an ignored request mid-token
    idle_hold(100);

    // reset during the 20th DATA bit of a CMD8
    start_i     = 1'b1;
    cmd_index_i = vecs[1].idx;
    cmd_arg_i   = vecs[1].arg;
    step();
    start_i = 1'b0;
    repeat (19) step();
    check("reset_mid_oe", 64'(cmd_oe_o), 64'd1);
    rst_i = 1'b1;
    step();
    check("reset_mid_outputs", 64'({cmd_oe_o, cmd_o, ready_o, done_o}), 64'(4'b0110));
    rst_i = 1'b0;
    step();
    check("reset_mid_no_done", 64'({cmd_oe_o, cmd_o, ready_o, done_o}), 64'(4'b0110));
    send_tok(0, 1'b0, -1);   // CMD0 after abandoned token

    idle_hold(20);
    check("done_count", 64'(done_seen), 64'(exp_done));
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_tx.md
# sd_cmd_tx

Serializes an SD command token (start bit, transmission bit, 6-bit index, 32-bit argument, CRC7, end bit; 48 bits total) onto the CMD line, MSB first, one bit per `sd_clk_i`. CRC7 (x^7 + x^3 + 1) is generated on the fly over the first 40 bits. The block is the transmit counterpart of the response-read CRC path and sits between the host command register logic and the CMD pad. The pad uses `cmd_o` and `cmd_oe_o`.

## Interface
- No parameters.
- `sd_clk_i`  in  1  SD clock; all state updates on its rising edge.
- `rst_i`  in  1  Reset; synchronous, active-high.
- `start_i`  in  1  Request to send; accepted only when `ready_o`=1.
- `cmd_index_i`  in  6  Command index; sampled on the accept cycle.
- `cmd_arg_i`  in  32  Command argument; sampled on the accept cycle.
- `ready_o`  out  1  Block idle; a request can be accepted.
- `cmd_o`  out  1  Serial CMD data; registered.
- `cmd_oe_o`  out  1  Output enable for the CMD pad; registered.
- `done_o`  out  1  One-cycle pulse when the token (and gap, if enabled) has completed.

## Operation
- **Reset values:**
  - `ready_o`=1, `cmd_o`=1, `cmd_oe_o`=0, `done_o`=0.
  - CRC register = 0; state = IDLE.
- **States:** IDLE, DATA, CRC, END, and GAP (GAP exists only when `SD_CMD_TX_GAP_EN` is defined).
- **IDLE:**
  - `cmd_oe_o`=0 and `cmd_o`=1.
  - When `start_i` is high: latch `{2'b01, cmd_index_i, cmd_arg_i}` into a 40-bit shift register, clear the CRC, clear the bit counter, and go to DATA.
- **DATA (40 cycles, counter 0..39):**
  - Drive shift[39] and shift left.
  - CRC update: `fb = bit ^ crc[6]`; `crc = {crc[5:3], crc[2]^fb, crc[1:0], fb}`.
  - When the counter reaches 39, go to CRC.
- **CRC (7 cycles):** drive crc[6] and shift left with zero fill; no feedback. After 7 bits go to END.
- **END (1 cycle):** drive 1. Then go to GAP if enabled, otherwise IDLE.
- **Output enable:** `cmd_oe_o`=1 throughout DATA, CRC and END.
- **Ignored requests:** `start_i` while `ready_o`=0 is ignored. It is neither queued nor an error.
- **Input stability:** `cmd_index_i` and `cmd_arg_i` may change freely after the accept cycle.
- **Reset mid-token:** the next cycle gives IDLE outputs (`cmd_oe_o`=0, `cmd_o`=1). No `done_o` is issued and the partial token is abandoned.
- **`done_o`:** asserted for exactly one cycle, on the first cycle in which IDLE outputs are presented after a completed token.

## Timing
- Accept in cycle N, meaning `start_i`=1 and `ready_o`=1 at the rising edge ending cycle N.
- `ready_o` is 0 from cycle N+1.
- Token bit k (k=0 is the start bit) appears on `cmd_o` in cycle N+1+k, for k = 0..47:
  - start bit 0 in N+1;
  - transmission bit 1 in N+2;
  - index in N+3..N+8;
  - argument in N+9..N+40;
  - CRC in N+41..N+47;
  - end bit in N+48.
- Without the gap: `ready_o`=1 and `done_o`=1 in cycle N+49.
- Back-to-back: a `start_i` held high in N+49 is accepted, and its start bit appears in N+50.
- The CRC covers exactly token bits 0..39. The first CRC bit is the CRC value after bit 39 has been absorbed.

## Configuration
- `SD_CMD_TX_GAP_EN` defined:
  - After END, the block enters GAP for 8 cycles (N+49..N+56) with `cmd_oe_o`=1 and `cmd_o`=1.
  - `ready_o`=1 and `done_o`=1 in N+57.
  - This guarantees the N_CC spacing between commands.
- Not defined:
  - The GAP state and its counter are absent.
  - `ready_o`=1 and `done_o`=1 in N+49.

## Test plan
- **CMD0:** index 0, arg 0x00000000 -> serial token 0x40_00000000_95 (CRC7 0x4A). `done_o` pulses once at N+49 (N+57 with gap).
- **CMD8:** index 8, arg 0x000001AA -> token 0x48_000001AA_87 (CRC7 0x43).
- **Back-to-back with `start_i` held high:** CMD17 arg 0 (0x51_00000000_55), then CMD55 arg 0 (0x77_00000000_65).
  - The second start bit follows the first end bit after exactly 1 idle cycle (no gap) or 9 idle cycles (with gap).
- **`start_i` pulsed during DATA with a different index:** the current token is unchanged, no second token follows, and there is exactly one `done_o`.
- **`rst_i` asserted at the 20th DATA bit:**
  - Next cycle: `cmd_oe_o`=0, `cmd_o`=1, `ready_o`=1, with no `done_o`.
  - A subsequent CMD0 is transmitted correctly, showing the CRC was cleared.
- **Idle hold:** 100 cycles with `start_i`=0 -> `cmd_oe_o`=0, `cmd_o`=1, `done_o`=0 throughout.
